branch_resolve_unit: RTL

Parametrised, pipelined branch/jump resolution stage for the RISC-V execute path. It evaluates all six conditional branch conditions plus JAL/JALR, computes the actual target and link values, and compares the outcome against the front-end prediction to raise a redirect. It has valid/ready handshakes, one registered output stage, flush support and saturating statistics counters. It sits between register-file operand read and the fetch redirect/commit logic.

---
 rtl/branch_resolve_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves RISC-V conditional branches, JAL and JALR against the
// front-end prediction, behind a single registered valid/ready output stage.
//   clk, reset_n               clock, asynchronous active-low reset
//   in_valid/in_ready          request handshake
//   opcode, funct3             instruction decode fields
//   rs1_data, rs2_data, pc, imm  operands, instruction PC, sign-extended immediate
//   pred_taken, pred_target    front-end prediction
//   flush                      drop the held result and refuse input this cycle
//   cnt_clr                    synchronous clear of the statistics counters
//   out_valid/out_ready        result handshake
//   taken, target, link        actual outcome and pc+4 writeback value
//   redirect, redirect_pc      misprediction and restart address
//   illegal                    branch opcode with reserved funct3
//   br_count, mispred_count    saturating statistics
module branch_resolve_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  link,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             illegal,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);
    localparam logic [6:0]       OP_BR   = 7'b1100011;
    localparam logic [6:0]       OP_JAL  = 7'b1101111;
    localparam logic [6:0]       OP_JALR = 7'b1100111;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic            w_is_br, w_is_jal, w_is_jalr, w_ctrl;
    logic            w_eq, w_lt, w_ltu, w_cond, w_taken, w_illegal, w_redirect;
    logic            w_accept, w_out_hs;
    logic [XLEN-1:0] w_pc4, w_pc_imm, w_jalr_tgt, w_target;

    logic            r_valid, r_taken, r_redirect, r_illegal, r_ctrl;
    logic [XLEN-1:0] r_target, r_link, r_redirect_pc;
    logic [CNT_W-1:0] r_br_cnt, r_mis_cnt;

    assign w_is_br   = opcode == OP_BR;
    assign w_is_jal  = opcode == OP_JAL;
    assign w_is_jalr = opcode == OP_JALR;
    assign w_ctrl    = w_is_br || w_is_jal || w_is_jalr;

    assign w_eq  = rs1_data == rs2_data;
    assign w_lt  = $signed(rs1_data) < $signed(rs2_data);
    assign w_ltu = rs1_data < rs2_data;

    // funct3[0] inverts the base compare; 010/011 are reserved and never taken
    assign w_cond = funct3 == 3'b000 ? w_eq  :
                    funct3 == 3'b001 ? !w_eq :
                    funct3 == 3'b100 ? w_lt  :
                    funct3 == 3'b101 ? !w_lt :
                    funct3 == 3'b110 ? w_ltu :
                    funct3 == 3'b111 ? !w_ltu : 1'b0;

    assign w_illegal  = w_is_br && (funct3 == 3'b010 || funct3 == 3'b011);
    assign w_taken    = w_is_br ? w_cond : (w_is_jal || w_is_jalr);
    assign w_pc4      = pc + XLEN'(4);
    assign w_pc_imm   = pc + imm;
    assign w_jalr_tgt = (rs1_data + imm) & {{(XLEN-1){1'b1}}, 1'b0};
    assign w_target   = w_is_jalr ? w_jalr_tgt : (w_is_br || w_is_jal) ? w_pc_imm : w_pc4;
    assign w_redirect = (w_taken != pred_taken) || (w_taken && w_target != pred_target);

    assign in_ready = (!r_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;
    // a flush overrides the consumer handshake, so the dropped entry is never counted
    assign w_out_hs = r_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid       <= 1'b0;
            r_taken       <= 1'b0;
            r_redirect    <= 1'b0;
            r_illegal     <= 1'b0;
            r_ctrl        <= 1'b0;
            r_target      <= '0;
            r_link        <= '0;
            r_redirect_pc <= '0;
        end else begin
            r_valid <= flush ? 1'b0 : w_accept ? 1'b1 : w_out_hs ? 1'b0 : r_valid;
            if (w_accept) begin
                r_taken       <= w_taken;
                r_redirect    <= w_redirect;
                r_illegal     <= w_illegal;
                r_ctrl        <= w_ctrl;
                r_target      <= w_target;
                r_link        <= w_pc4;
                r_redirect_pc <= w_taken ? w_target : w_pc4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            r_br_cnt  <= cnt_clr ? '0 :
                         (w_out_hs && r_ctrl && r_br_cnt != CNT_MAX) ? r_br_cnt + CNT_W'(1) : r_br_cnt;
            r_mis_cnt <= cnt_clr ? '0 :
                         (w_out_hs && r_redirect && r_mis_cnt != CNT_MAX) ? r_mis_cnt + CNT_W'(1) : r_mis_cnt;
        end
    end

    // flags read as 0 whenever no result is held
    assign out_valid     = r_valid;
    assign taken         = r_valid && r_taken;
    assign redirect      = r_valid && r_redirect;
    assign illegal       = r_valid && r_illegal;
    assign target        = r_target;
    assign link          = r_link;
    assign redirect_pc   = r_redirect_pc;
    assign br_count      = r_br_cnt;
    assign mispred_count = r_mis_cnt;
endmodule
